// File: rtl/multi_dev_bridge.sv
// Handshaked bridge from the CPU data port to up to eight memory-mapped devices.
// Decodes fixed-size windows, holds each access until acked or timed out, and registers device IRQs.
module multi_dev_bridge #(
   parameter int          NUM_DEV   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
   parameter int          WIN_AW    = 4,
   parameter int          TIMEOUT   = 15,
   parameter logic [31:0] MISS_DATA = 32'h2333_3333
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    pr_req,
   input  logic                    pr_we,
   input  logic [31:2]             pr_addr,
   input  logic [31:0]             pr_wd,
   input  logic [3:0]              pr_be,
   output logic [31:0]             pr_rd,
   output logic                    pr_ready,
   output logic                    pr_err,
   output logic [NUM_DEV-1:0]      dev_sel,
   output logic [NUM_DEV-1:0]      dev_we,
   output logic [WIN_AW-1:2]       dev_addr,
   output logic [31:0]             dev_wd,
   output logic [3:0]              dev_be,
   input  logic [NUM_DEV*32-1:0]   dev_rd,
   input  logic [NUM_DEV-1:0]      dev_ack,
   input  logic [NUM_DEV-1:0]      dev_irq,
   output logic [NUM_DEV-1:0]      hw_int
);

   localparam int              HI_W        = 32 - WIN_AW;
   localparam logic [HI_W-1:0] BASE_HI     = BASE_ADDR[31:WIN_AW];
   localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [31:0]          pr_rd_q, pr_rd_d;
   logic                 pr_err_q, pr_err_d;
   logic [NUM_DEV-1:0]   dev_sel_q, dev_sel_d;
   logic [NUM_DEV-1:0]   dev_we_q, dev_we_d;
   logic [WIN_AW-1:2]    dev_addr_q, dev_addr_d;
   logic [31:0]          dev_wd_q, dev_wd_d;
   logic [3:0]           dev_be_q, dev_be_d;
   logic [NUM_DEV-1:0]   hw_int_q, hw_int_d;

   logic [NUM_DEV-1:0]   hit_vec;
   logic [31:0]          sel_rd;
   logic                 ack_hit;

   // Window decode: device i owns the i-th window above the base.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (pr_addr[31:WIN_AW] == BASE_HI + HI_W'(i)) hit_vec[i] = 1'b1;
      end
   end

   always_comb begin
      sel_rd = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (dev_sel_q[i]) sel_rd = sel_rd | dev_rd[i*32 +: 32];
      end
   end

   // Acks from devices other than the selected one are masked off.
   assign ack_hit = |(dev_sel_q & dev_ack);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pr_rd_d    = pr_rd_q;
      pr_err_d   = pr_err_q;
      dev_sel_d  = dev_sel_q;
      dev_we_d   = dev_we_q;
      dev_addr_d = dev_addr_q;
      dev_wd_d   = dev_wd_q;
      dev_be_d   = dev_be_q;
      hw_int_d   = dev_irq;

      case (state_q)
         IDLE: begin
            if (pr_req) begin
               if (|hit_vec) begin
                  dev_addr_d = pr_addr[WIN_AW-1:2];
                  dev_wd_d   = pr_wd;
                  dev_be_d   = pr_be;
                  dev_sel_d  = hit_vec;
                  dev_we_d   = hit_vec & {NUM_DEV{pr_we}};
                  cnt_d      = '0;
                  state_d    = ACCESS;
               end else begin
                  pr_rd_d  = MISS_DATA;
                  pr_err_d = 1'b1;
                  state_d  = RESP;
               end
            end
         end
         ACCESS: begin
            // An ack arriving in the timeout cycle still completes normally.
            if (ack_hit) begin
               pr_rd_d   = (|dev_we_q) ? 32'h0 : sel_rd;
               pr_err_d  = 1'b0;
               dev_sel_d = '0;
               dev_we_d  = '0;
               state_d   = RESP;
            end else if (cnt_q == TIMEOUT_CNT) begin
               pr_rd_d   = MISS_DATA;
               pr_err_d  = 1'b1;
               dev_sel_d = '0;
               dev_we_d  = '0;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pr_rd_q    <= '0;
         pr_err_q   <= 1'b0;
         dev_sel_q  <= '0;
         dev_we_q   <= '0;
         dev_addr_q <= '0;
         dev_wd_q   <= '0;
         dev_be_q   <= '0;
         hw_int_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pr_rd_q    <= pr_rd_d;
         pr_err_q   <= pr_err_d;
         dev_sel_q  <= dev_sel_d;
         dev_we_q   <= dev_we_d;
         dev_addr_q <= dev_addr_d;
         dev_wd_q   <= dev_wd_d;
         dev_be_q   <= dev_be_d;
         hw_int_q   <= hw_int_d;
      end
   end

   assign pr_rd    = pr_rd_q;
   assign pr_ready = (state_q == RESP);
   assign pr_err   = pr_err_q;
   assign dev_sel  = dev_sel_q;
   assign dev_we   = dev_we_q;
   assign dev_addr = dev_addr_q;
   assign dev_wd   = dev_wd_q;
   assign dev_be   = dev_be_q;
   assign hw_int   = hw_int_q;

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Directed bench for multi_dev_bridge: table of single transactions plus hand-written
// sequences for reset during an access, back-to-back requests and IRQ registering.
module tb_multi_dev_bridge;

   localparam int NUM_DEV = 2;
   localparam int WIN_AW  = 4;
   localparam logic [31:0] MISS = 32'h2333_3333;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   pr_req = 1'b0;
   logic                   pr_we = 1'b0;
   logic [31:2]            pr_addr = '0;
   logic [31:0]            pr_wd = '0;
   logic [3:0]             pr_be = '0;
   logic [31:0]            pr_rd;
   logic                   pr_ready;
   logic                   pr_err;
   logic [NUM_DEV-1:0]     dev_sel;
   logic [NUM_DEV-1:0]     dev_we;
   logic [WIN_AW-1:2]      dev_addr;
   logic [31:0]            dev_wd;
   logic [3:0]             dev_be;
   logic [NUM_DEV*32-1:0]  dev_rd = '0;
   logic [NUM_DEV-1:0]     dev_ack = '0;
   logic [NUM_DEV-1:0]     dev_irq = '0;
   logic [NUM_DEV-1:0]     hw_int;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_dev_bridge #(
      .NUM_DEV  (NUM_DEV),
      .BASE_ADDR(32'h0000_7F00),
      .WIN_AW   (WIN_AW),
      .TIMEOUT  (15),
      .MISS_DATA(MISS)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pr_req  (pr_req),
      .pr_we   (pr_we),
      .pr_addr (pr_addr),
      .pr_wd   (pr_wd),
      .pr_be   (pr_be),
      .pr_rd   (pr_rd),
      .pr_ready(pr_ready),
      .pr_err  (pr_err),
      .dev_sel (dev_sel),
      .dev_we  (dev_we),
      .dev_addr(dev_addr),
      .dev_wd  (dev_wd),
      .dev_be  (dev_be),
      .dev_rd  (dev_rd),
      .dev_ack (dev_ack),
      .dev_irq (dev_irq),
      .hw_int  (hw_int)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] baddr;
      logic [31:0] wd;
      logic [3:0]  be;
      int          ack_cyc;   // cycle after the request edge in which ack is high; 0 = never
      int          ack_dev;
      logic [31:0] rdata;
      logic [1:0]  exp_sel;
      logic [1:0]  exp_addr;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;   // cycle in which pr_ready is high
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pr_rd"}, pr_rd, 32'h0);
      chk({tag, "_dev_wd"}, dev_wd, 32'h0);
      chk({tag, "_ctl"}, 32'({pr_ready, pr_err, dev_sel, dev_we, dev_addr, dev_be, hw_int}), 32'h0);
   endtask

   task automatic run_txn(input vec_t v);
      int   lat;
      logic seen;
      logic hold_ok;
      logic [1:0] exp_we;
      exp_we  = v.we ? v.exp_sel : 2'b00;
      lat     = 0;
      seen    = 1'b0;
      hold_ok = 1'b1;
      if (v.ack_dev == 1) dev_rd = {v.rdata, ~v.rdata};
      else                dev_rd = {~v.rdata, v.rdata};
      pr_req  = 1'b1;
      pr_we   = v.we;
      pr_addr = v.baddr[31:2];
      pr_wd   = v.wd;
      pr_be   = v.be;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         dev_ack = '0;
         if (lat == v.ack_cyc) dev_ack[v.ack_dev] = 1'b1;
         @(negedge clk);
         if (lat < v.exp_lat) begin
            if (dev_sel !== v.exp_sel || dev_we !== exp_we) hold_ok = 1'b0;
         end else begin
            if (dev_sel !== 2'b00 || dev_we !== 2'b00) hold_ok = 1'b0;
         end
         if (lat == 1 && v.exp_sel != 2'b00) begin
            chk({v.name, "_dev_addr"}, 32'(dev_addr), 32'(v.exp_addr));
            chk({v.name, "_dev_wd"}, dev_wd, v.wd);
            chk({v.name, "_dev_be"}, 32'(dev_be), 32'(v.be));
         end
         if (pr_ready) begin
            seen   = 1'b1;
            pr_req = 1'b0;
         end
      end
      pr_req  = 1'b0;
      dev_ack = '0;
      chk({v.name, "_sel_we_hold"}, 32'(hold_ok), 32'h1);
      chk({v.name, "_latency"}, lat, v.exp_lat);
      chk({v.name, "_pr_rd"}, pr_rd, v.exp_rd);
      chk({v.name, "_pr_err"}, 32'(pr_err), 32'(v.exp_err));
      // One cycle later: pulse gone, response data held.
      @(negedge clk);
      chk({v.name, "_ready_pulse"}, 32'(pr_ready), 32'h0);
      chk({v.name, "_rd_hold"}, {pr_rd[31:1], pr_err ^ pr_rd[0]}, {v.exp_rd[31:1], v.exp_err ^ v.exp_rd[0]});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy_cnt;

      vecs[0] = '{"rd_hit_dev1",   1'b0, 32'h0000_7F14, 32'h0,          4'hF,   1, 1, 32'hDEAD_BEEF, 2'b10, 2'd1, 32'hDEAD_BEEF, 1'b0,  2};
      vecs[1] = '{"wr_wait_dev0",  1'b1, 32'h0000_7F08, 32'h1234_5678,  4'b0011, 4, 0, 32'hFFFF_FFFF, 2'b01, 2'd2, 32'h0,         1'b0,  5};
      vecs[2] = '{"miss_above",    1'b0, 32'h0000_7F20, 32'h0,          4'hF,   1, 0, 32'h5555_5555, 2'b00, 2'd0, MISS,          1'b1,  1};
      vecs[3] = '{"rd_hit_dev0",   1'b0, 32'h0000_7F0C, 32'h0,          4'hF,   2, 0, 32'h0BAD_F00D, 2'b01, 2'd3, 32'h0BAD_F00D, 1'b0,  3};
      vecs[4] = '{"miss_below",    1'b0, 32'h0000_7EFC, 32'h0,          4'hF,   1, 0, 32'h5555_5555, 2'b00, 2'd0, MISS,          1'b1,  1};
      vecs[5] = '{"timeout",       1'b0, 32'h0000_7F00, 32'h0,          4'hF,   0, 0, 32'h7777_7777, 2'b01, 2'd0, MISS,          1'b1, 17};
      vecs[6] = '{"ack_at_tmo",    1'b0, 32'h0000_7F00, 32'h0,          4'hF,  16, 0, 32'hA5A5_0F0F, 2'b01, 2'd0, 32'hA5A5_0F0F, 1'b0, 17};
      vecs[7] = '{"unsel_ack",     1'b0, 32'h0000_7F04, 32'h0,          4'hF,   1, 1, 32'h1357_9BDF, 2'b01, 2'd1, MISS,          1'b1, 17};
      vecs[8] = '{"wr_hit_dev1",   1'b1, 32'h0000_7F1C, 32'hCAFE_BABE,  4'b1100, 1, 1, 32'h8888_8888, 2'b10, 2'd3, 32'h0,        1'b0,  2};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Reset during ACCESS: abort without a ready pulse
      pr_req  = 1'b1;
      pr_we   = 1'b1;
      pr_addr = 30'h0000_1FC0;
      pr_wd   = 32'hCAFE_F00D;
      pr_be   = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_busy_sel", 32'(dev_sel), 32'h1);
      reset_n = 1'b0;
      pr_req  = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      @(negedge clk);
      reset_n = 1'b1;
      rdy_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pr_ready) rdy_cnt++;
      end
      chk("mid_rst_no_ready", rdy_cnt, 0);
      run_txn(vecs[0]);

      // Back-to-back: request held across two hits on different devices
      dev_rd  = {32'h2222_2222, 32'h1111_1111};
      pr_req  = 1'b1;
      pr_we   = 1'b0;
      pr_addr = 30'h0000_1FC0;
      @(posedge clk); #1;
      dev_ack = 2'b01;
      @(negedge clk);
      chk("b2b_first_sel", 32'(dev_sel), 32'h1);
      @(posedge clk); #1;
      dev_ack = 2'b00;
      @(negedge clk);
      chk("b2b_first_ready", 32'({pr_ready, pr_err}), 32'h2);
      chk("b2b_first_rd", pr_rd, 32'h1111_1111);
      pr_addr = 30'h0000_1FC4;
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_idle_gap", 32'({pr_ready, dev_sel}), 32'h0);
      @(posedge clk); #1;
      dev_ack = 2'b10;
      @(negedge clk);
      chk("b2b_second_sel", 32'(dev_sel), 32'h2);
      @(posedge clk); #1;
      dev_ack = 2'b00;
      @(negedge clk);
      chk("b2b_second_ready", 32'({pr_ready, pr_err}), 32'h2);
      chk("b2b_second_rd", pr_rd, 32'h2222_2222);
      pr_req = 1'b0;

      // IRQ registering: one-cycle delay, independent of the FSM
      dev_irq = 2'b10;
      #1;
      chk("irq_not_yet", 32'(hw_int), 32'h0);
      @(posedge clk); #1;
      chk("irq_rise", 32'(hw_int), 32'h2);
      @(negedge clk);
      dev_irq = 2'b01;
      #1;
      chk("irq_hold", 32'(hw_int), 32'h2);
      @(posedge clk); #1;
      chk("irq_change", 32'(hw_int), 32'h1);
      @(negedge clk);
      dev_irq = 2'b00;
      @(posedge clk); #1;
      chk("irq_clear", 32'(hw_int), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
